// File: rtl/sser_key_rx.sv
// Serial key receiver: assembles a start-framed word from the sequencer's SDRD
// bit on key-window reads and raises unlock on match, fail pulse/count otherwise.
module sser_key_rx #(
    parameter int                  KEY_BITS = 16,
    parameter logic [KEY_BITS-1:0] KEY      = 16'hA55A,
    parameter int                  TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_stb,
    input  logic                sser_n,
    input  logic                ba13,
    input  logic                ba12,
    input  logic                br_w,
    input  logic                sdrd,
    input  logic                clr,
    output logic                busy,
    output logic                unlock,
    output logic                fail,
    output logic [1:0]          fail_cnt,
    output logic [KEY_BITS-1:0] rx_word
);
    localparam int CW = $clog2(KEY_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t              r_state, w_next;
    logic [KEY_BITS-1:0] r_sreg;
    logic [CW-1:0]       r_cnt;
    logic [TW-1:0]       r_to;
    logic                r_unlock, r_fail;
    logic [1:0]          r_fail_cnt;
    logic [KEY_BITS-1:0] r_rx_word;
    logic                w_qs, w_last_bit, w_expire;

    assign w_qs       = bus_stb & ~sser_n & ~ba13 & ba12 & br_w;
    assign w_last_bit = (r_cnt == CW'(KEY_BITS - 1));
    assign w_expire   = (r_to == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_qs && sdrd) w_next = SHIFT;
            SHIFT: begin
                if (w_qs) begin
                    if (w_last_bit) w_next = CHECK;
                end else if (w_expire) begin
                    w_next = IDLE;
                end
            end
            CHECK:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (clr) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg     <= '0;
            r_cnt      <= '0;
            r_to       <= '0;
            r_unlock   <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_cnt <= 2'd0;
            r_rx_word  <= '0;
        end else if (clr) begin
            // rx_word is deliberately held so software can still inspect it
            r_cnt      <= '0;
            r_to       <= '0;
            r_unlock   <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_cnt <= 2'd0;
        end else begin
            r_fail <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_qs && sdrd) begin
                        r_cnt <= '0;
                        r_to  <= '0;
                    end
                end
                SHIFT: begin
                    if (w_qs) begin
                        r_sreg <= KEY_BITS'({r_sreg, sdrd});
                        r_cnt  <= r_cnt + CW'(1);
                        r_to   <= '0;
                    end else begin
                        r_to   <= w_expire ? '0 : r_to + TW'(1);
                    end
                end
                CHECK: begin
                    r_rx_word <= r_sreg;
                    if (r_sreg == KEY) begin
                        r_unlock <= 1'b1;
                    end else begin
                        r_unlock <= 1'b0;
                        r_fail   <= 1'b1;
                        if (r_fail_cnt != 2'd3) r_fail_cnt <= r_fail_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign unlock   = r_unlock;
    assign fail     = r_fail;
    assign fail_cnt = r_fail_cnt;
    assign rx_word  = r_rx_word;

endmodule

// File: doc/sser_key_rx.md
Name: sser_key_rx

Overview:
- Downstream consumer of the serial key sequencer's read-data output (SDRD).
- On every qualified key-window bus read (SSER low, BA13 low, BA12 high, read), it samples the sequencer's serial bit and assembles a start-framed key word MSB first.
- It compares the word against a constant and raises a sticky unlock flag or a fail pulse/count.
- It runs on the system clock; the bus cycle completion arrives as a one-clock strobe.

Parameters:
KEY_BITS, 16, number of data bits per frame after the start bit
KEY, 16'hA55A, expected key value, MSB received first
TIMEOUT, 255, max clocks between qualified strobes inside a frame before abort (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
bus_stb  input  1  one-clock pulse marking completion of a CPU bus cycle
sser_n  input  1  serial-key select, active low (SSER)
ba13  input  1  address bit 13
ba12  input  1  address bit 12
br_w  input  1  bus read/write, 1 = read
sdrd  input  1  serial data bit from key sequencer, valid when bus_stb=1
clr  input  1  synchronous clear of unlock, fail_cnt and frame state
busy  output  1  frame reception in progress
unlock  output  1  sticky: last completed frame matched KEY
fail  output  1  one-clock pulse on mismatch
fail_cnt  output  2  saturating count of mismatches
rx_word  output  KEY_BITS  last completed frame's data

Behaviour:
- Qualified sample: qs = bus_stb & ~sser_n & ~ba13 & ba12 & br_w. Non-qualified strobes are ignored and do not reset the timeout.
- Reset (rst_n=0, async):
  - state=IDLE; busy=0, unlock=0, fail=0, fail_cnt=0, rx_word=0.
  - Internal shift register, bit counter and timeout counter are 0.
- States: IDLE, SHIFT, CHECK.
- IDLE:
  - qs with sdrd=1 (start bit): go to SHIFT, bit counter=0, timeout=0, busy=1 from the next clock.
  - qs with sdrd=0: stay in IDLE.
- SHIFT:
  - Each qs shifts sdrd into the shift register LSB (earlier bits move up), increments the bit counter and clears the timeout.
  - When the KEY_BITS-th bit is shifted, go to CHECK.
  - With no qs, the timeout increments. When it reaches TIMEOUT, go to IDLE and set busy=0. The partial word is discarded; rx_word, unlock and fail are unchanged.
- CHECK (exactly 1 clock; qs in this cycle is ignored):
  - rx_word <= shift register.
  - If it equals KEY: unlock <= 1.
  - Otherwise: unlock <= 0, fail=1 for this one clock, and fail_cnt increments, saturating at 3.
  - Next state IDLE; busy=0 on the following clock.
- Latency:
  - Last data qs at edge N puts the block in CHECK for cycle N+1.
  - unlock, fail and rx_word are updated at edge N+2. The fail pulse is high for the single cycle following edge N+2.
- clr=1:
  - Next edge forces state=IDLE; busy, unlock, fail and fail_cnt go to 0. rx_word is held.
  - clr has priority over qs, CHECK results and timeout in the same cycle.
- A new frame may start on the first qs after returning to IDLE; there is no minimum gap.
- A match after earlier fails sets unlock but does not clear fail_cnt.
- bit counter width: clog2(KEY_BITS+1). Timeout width: clog2(TIMEOUT+1).
- Reset asserted mid-frame returns to the reset state immediately.

Test Plan:
- Reset then frame: qs with sdrd=1, then 16 qs carrying 0xA55A MSB first -> busy=1 during frame; 2 clocks after last qs, rx_word=0xA55A, unlock=1, fail never asserted, fail_cnt=0, busy=0.
- Mismatch: frame with 0xA55B -> rx_word=0xA55B, unlock=0, fail high exactly 1 clock, fail_cnt=1. Repeat 3 more times -> fail_cnt saturates at 3.
- Qualification: during a frame, strobes with sser_n=1, ba13=1, ba12=0 or br_w=0 toggle sdrd -> ignored; the bit count advances only on qualified strobes, and the correct key still unlocks.
- Timeout: start bit plus 5 data bits, then 255 idle clocks -> busy=0 at timeout; unlock/rx_word/fail_cnt unchanged. A following full 0xA55A frame unlocks normally.
- clr priority: clr asserted in the same cycle as CHECK of a matching frame -> unlock=0, fail_cnt=0, state IDLE. Also qs with sdrd=0 while IDLE -> no frame starts.
- Async reset: rst_n pulsed low mid-frame (after 8 bits) with clk stopped -> busy=0 and unlock=0 immediately. A fresh frame then behaves as in scenario 1.
